// File: rtl/esc_pkg.sv
// Shared constants and helpers for the multi-channel ESC/servo PWM generator.
package esc_pkg;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_IN_W        = 8;
    localparam int unsigned DEF_CLK_DIV     = 100;
    localparam int unsigned DEF_FRAME_TICKS = 1000;
    localparam int unsigned DEF_MIN_TICKS   = 25;
    localparam int unsigned DEF_SPAN_TICKS  = 100;
    localparam int unsigned DEF_SLEW_TICKS  = 5;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Normalised command -> pulse width in ticks, floor-rounded.
    function automatic int unsigned cmd_to_ticks(
        input int unsigned cmd,
        input int unsigned in_w,
        input int unsigned min_ticks,
        input int unsigned span_ticks
    );
        int unsigned full_scale;
        int unsigned prod;
        full_scale = (32'd1 << in_w) - 32'd1;
        prod       = cmd * span_ticks;
        return min_ticks + (prod / full_scale);
    endfunction

endpackage

// File: rtl/esc_pwm_channel.sv
// One PWM channel: shadow/active width pair and the registered compare output.
// Build option ESC_SLEW_EN limits how far the active width moves per frame.
module esc_pwm_channel
    import esc_pkg::*;
#(
    parameter int unsigned W_W        = 10,
    parameter int unsigned MIN_TICKS  = DEF_MIN_TICKS
`ifdef ESC_SLEW_EN
    ,
    parameter int unsigned SLEW_TICKS = DEF_SLEW_TICKS
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           fs_i,
    input  logic           wr_en_i,
    input  logic [W_W-1:0] wr_ticks_i,
    input  logic [W_W-1:0] frame_cnt_i,
    output logic           pwm_o
);

    localparam logic [W_W-1:0] MIN_W = W_W'(MIN_TICKS);
`ifdef ESC_SLEW_EN
    localparam logic [W_W-1:0] SLEW_W = W_W'(SLEW_TICKS);
`endif

    logic [W_W-1:0] shadow_q, shadow_d;
    logic [W_W-1:0] active_q, active_d;
    logic           pwm_q, pwm_d;

    always_comb begin
        shadow_d = wr_en_i ? wr_ticks_i : shadow_q;
        active_d = active_q;
        // At frame_cnt==0 any legal width compares true, so the old active is safe here.
        pwm_d    = en_i && (frame_cnt_i < active_q);
        if (fs_i) begin
`ifdef ESC_SLEW_EN
            if (shadow_q >= active_q) begin
                active_d = ((shadow_q - active_q) > SLEW_W) ? (active_q + SLEW_W) : shadow_q;
            end else begin
                active_d = ((active_q - shadow_q) > SLEW_W) ? (active_q - SLEW_W) : shadow_q;
            end
`else
            active_d = shadow_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= MIN_W;
            active_q <= MIN_W;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_multi.sv
// Multi-channel ESC/servo PWM generator: shared prescaler/frame counter, double-buffered widths.
// Build option ESC_SLEW_EN enables per-frame slew limiting of the active widths.
module esc_pwm_multi
    import esc_pkg::*;
#(
    parameter  int unsigned N_CH        = DEF_N_CH,
    parameter  int unsigned IN_W        = DEF_IN_W,
    parameter  int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter  int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
    parameter  int unsigned MIN_TICKS   = DEF_MIN_TICKS,
    parameter  int unsigned SPAN_TICKS  = DEF_SPAN_TICKS,
    parameter  int unsigned SLEW_TICKS  = DEF_SLEW_TICKS,
    localparam int unsigned CH_W        = ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CH_W-1:0] cmd_ch,
    input  logic [IN_W-1:0] cmd_val,
    output logic            cmd_err,
    output logic            frame_start,
    output logic [N_CH-1:0] pwm
);

    localparam int unsigned W_W    = $clog2(FRAME_TICKS);
    localparam int unsigned P_W    = $clog2(CLK_DIV);
    localparam int unsigned PROD_W = IN_W + $clog2(SPAN_TICKS + 1);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("esc_pwm_multi: N_CH must be in 1..16");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("esc_pwm_multi: CLK_DIV must be at least 2");
    end
    if (MIN_TICKS + SPAN_TICKS >= FRAME_TICKS) begin : g_bad_span
        $error("esc_pwm_multi: MIN_TICKS + SPAN_TICKS must be below FRAME_TICKS");
    end
    if (PROD_W > 32) begin : g_bad_prod
        $error("esc_pwm_multi: IN_W/SPAN_TICKS too large for the width conversion");
    end
    if (SLEW_TICKS == 0 || SLEW_TICKS >= FRAME_TICKS) begin : g_bad_slew
        $error("esc_pwm_multi: SLEW_TICKS must be in 1..FRAME_TICKS-1");
    end

    logic [P_W-1:0] presc_q, presc_d;
    logic [W_W-1:0] frame_q, frame_d;
    logic           frame_start_q;
    logic           cmd_err_q;
    logic           tick;
    logic           fs;
    logic           accept;
    logic           ch_ok;
    logic           wr_ok;
    logic [W_W-1:0] wr_ticks;

    assign tick = (presc_q == P_W'(CLK_DIV - 1));
    assign fs   = en && (presc_q == '0) && (frame_q == '0);

    // Counters free-run while enabled and collapse to frame start when disabled.
    always_comb begin
        presc_d = '0;
        frame_d = '0;
        if (en) begin
            presc_d = tick ? '0 : (presc_q + P_W'(1));
            frame_d = frame_q;
            if (tick) begin
                frame_d = (frame_q == W_W'(FRAME_TICKS - 1)) ? '0 : (frame_q + W_W'(1));
            end
        end
    end

    // Writes are blocked only in the frame-start cycle so the shadow copy is coherent.
    assign cmd_ready = !fs;
    assign accept    = cmd_valid && cmd_ready;
    assign ch_ok     = (32'(cmd_ch) < N_CH);
    assign wr_ok     = accept && ch_ok;
    assign wr_ticks  = W_W'(cmd_to_ticks(32'(cmd_val), IN_W, MIN_TICKS, SPAN_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            frame_q       <= '0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            frame_q       <= frame_d;
            frame_start_q <= fs;
            cmd_err_q     <= accept && !ch_ok;
        end
    end

    assign frame_start = frame_start_q;
    assign cmd_err     = cmd_err_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic wr_en;
        assign wr_en = wr_ok && (cmd_ch == CH_W'(c));

        esc_pwm_channel #(
            .W_W       (W_W),
            .MIN_TICKS (MIN_TICKS)
`ifdef ESC_SLEW_EN
            ,
            .SLEW_TICKS(SLEW_TICKS)
`endif
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (en),
            .fs_i       (fs),
            .wr_en_i    (wr_en),
            .wr_ticks_i (wr_ticks),
            .frame_cnt_i(frame_q),
            .pwm_o      (pwm[c])
        );
    end

endmodule

// File: tb/tb_esc_pwm_multi.sv
// Self-checking bench for esc_pwm_multi against a frame-level width model.
module tb_esc_pwm_multi;

    localparam int N_CH        = 5;
    localparam int IN_W        = 8;
    localparam int CLK_DIV     = 4;
    localparam int FRAME_TICKS = 200;
    localparam int MIN_TICKS   = 25;
    localparam int SPAN_TICKS  = 100;
    localparam int SLEW_TICKS  = 5;
    localparam int CH_W        = 3;
    localparam int FC          = CLK_DIV * FRAME_TICKS;
    localparam int FULL        = (1 << IN_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [CH_W-1:0] cmd_ch = '0;
    logic [IN_W-1:0] cmd_val = '0;
    logic            cmd_ready;
    logic            cmd_err;
    logic            frame_start;
    logic [N_CH-1:0] pwm;

    esc_pwm_multi #(
        .N_CH       (N_CH),
        .IN_W       (IN_W),
        .CLK_DIV    (CLK_DIV),
        .FRAME_TICKS(FRAME_TICKS),
        .MIN_TICKS  (MIN_TICKS),
        .SPAN_TICKS (SPAN_TICKS),
        .SLEW_TICKS (SLEW_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_val    (cmd_val),
        .cmd_err    (cmd_err),
        .frame_start(frame_start),
        .pwm        (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {int k; int ch; int val;} wr_t;

    int  checks = 0;
    int  failures = 0;
    int  shadow_m[N_CH];
    int  active_m[N_CH];
    int  hi_cnt[N_CH];
    int  shape_err[N_CH];
    int  misc_fs, misc_rdy, misc_err;
    wr_t wq[$];
    bit  busy = 0, drop = 0, err_due = 0, err_exp = 0;

    function automatic int to_ticks(input int v);
        return MIN_TICKS + (v * SPAN_TICKS) / FULL;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame-start update of the model's active widths.
    task automatic apply_fs();
        for (int c = 0; c < N_CH; c++) begin
`ifdef ESC_SLEW_EN
            int d;
            d = shadow_m[c] - active_m[c];
            if (d > SLEW_TICKS) d = SLEW_TICKS;
            if (d < -SLEW_TICKS) d = -SLEW_TICKS;
            active_m[c] = active_m[c] + d;
`else
            active_m[c] = shadow_m[c];
`endif
        end
    endtask

    // Per-sample bookkeeping at a negedge; k is the clk index since frame start.
    task automatic step(input int k);
        if (drop) begin
            cmd_valid = 1'b0;
            drop = 0;
        end
        if (err_due) begin
            chk("cmd_err", 32'(cmd_err), 32'(err_exp));
            err_due = 0;
        end else if (cmd_err !== 1'b0) begin
            misc_err++;
        end
        if (k > 0 && frame_start !== 1'b0) misc_fs++;
        if (cmd_ready !== (k != FC - 1)) misc_rdy++;
        for (int c = 0; c < N_CH; c++) begin
            if (pwm[c] !== (k < active_m[c] * CLK_DIV)) shape_err[c]++;
            if (pwm[c] === 1'b1) hi_cnt[c]++;
        end
        if (!busy && wq.size() > 0 && wq[0].k <= k) begin
            cmd_ch    = CH_W'(wq[0].ch);
            cmd_val   = IN_W'(wq[0].val);
            cmd_valid = 1'b1;
            busy      = 1;
            void'(wq.pop_front());
        end
        if (busy && cmd_ready === 1'b1) begin
            if (int'(cmd_ch) < N_CH) shadow_m[int'(cmd_ch)] = to_ticks(int'(cmd_val));
            err_exp = (int'(cmd_ch) >= N_CH);
            err_due = 1;
            busy    = 0;
            drop    = 1;
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < N_CH; c++) begin
            hi_cnt[c]    = 0;
            shape_err[c] = 0;
        end
        misc_fs  = 0;
        misc_rdy = 0;
        misc_err = 0;
    endtask

    // Called on the frame_start sample; ends on the next frame_start sample.
    task automatic measure_frame(input string tag);
        apply_fs();
        clear_stats();
        chk({tag, ".frame_start"}, 32'(frame_start), 32'd1);
        for (int k = 0; k < FC; k++) begin
            if (k > 0) @(negedge clk);
            step(k);
        end
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("%s.ch%0d_high", tag, c), hi_cnt[c], active_m[c] * CLK_DIV);
            chk($sformatf("%s.ch%0d_shape", tag, c), shape_err[c], 0);
        end
        chk({tag, ".extra_frame_start"}, misc_fs, 0);
        chk({tag, ".ready_pattern"}, misc_rdy, 0);
        chk({tag, ".spurious_err"}, misc_err, 0);
        @(negedge clk);
    endtask

    task automatic idle_write(input int ch, input int val);
        @(negedge clk);
        cmd_ch    = CH_W'(ch);
        cmd_val   = IN_W'(val);
        cmd_valid = 1'b1;
        #1;
        chk("idle.ready", 32'(cmd_ready), 32'd1);
        if (ch < N_CH) shadow_m[ch] = to_ticks(val);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("idle.cmd_err", 32'(cmd_err), 32'(ch >= N_CH));
    endtask

    task automatic queue_random(input int n);
        int k;
        k = 1 + int'($urandom_range(0, 100));
        for (int i = 0; i < n && k < FC - 3; i++) begin
            wq.push_back('{k, int'($urandom_range(0, 7)), int'($urandom_range(0, FULL))});
            k = k + 2 + int'($urandom_range(0, 200));
        end
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            shadow_m[c] = MIN_TICKS;
            active_m[c] = MIN_TICKS;
        end

        // Reset state.
        #1 rst_n = 1'b0;
        #3;
        chk("rst.pwm", 32'(pwm), 32'd0);
        chk("rst.frame_start", 32'(frame_start), 32'd0);
        chk("rst.cmd_err", 32'(cmd_err), 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle.pwm", 32'(pwm), 32'd0);
        chk("idle.frame_start", 32'(frame_start), 32'd0);

        // Shadow write while disabled, then enable: first clk is a frame start.
        idle_write(4, 200);
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("en_rise.ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        measure_frame("f_base");

        // Mid-frame writes, out-of-range channel, last write wins on ch0.
        wq.push_back('{300, 1, 255});
        wq.push_back('{310, 2, 128});
        wq.push_back('{320, 3, 0});
        wq.push_back('{330, 5, 77});
        wq.push_back('{350, 0, 40});
        wq.push_back('{360, 0, 230});
        measure_frame("f_write");
        chk("model.ch2_ticks", active_m[2], 32'd25);
        measure_frame("f_apply");
        chk("model.ch2_applied", active_m[2] * CLK_DIV, 32'd300);

        // Command presented in the frame-start cycle waits one clk.
        wq.push_back('{FC - 1, 2, 64});
        measure_frame("f_hold");
        measure_frame("f_hold_next");

        for (int f = 0; f < 4; f++) begin
            queue_random(4);
            measure_frame($sformatf("f_rand%0d", f));
        end

        // en drop mid-pulse truncates immediately; en rise restarts a full frame.
        wq.push_back('{10, 1, 255});
        measure_frame("f_pre_en");
        apply_fs();
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            step(k);
        end
        chk("en_drop.ch1_high_before", 32'(pwm[1]), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop.pwm", 32'(pwm), 32'd0);
        repeat (37) @(negedge clk);
        chk("en_low.pwm", 32'(pwm), 32'd0);
        chk("en_low.frame_start", 32'(frame_start), 32'd0);
        idle_write(3, 255);
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("en_rerise.ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        measure_frame("f_en_rise");

        // Step ch0 to full scale and back; the model follows the build's slew rule.
        wq.push_back('{5, 0, 255});
        measure_frame("f_step_up");
        for (int f = 0; f < 20; f++) measure_frame($sformatf("f_up%0d", f));
        wq.push_back('{5, 0, 0});
        measure_frame("f_step_dn");
        for (int f = 0; f < 20; f++) measure_frame($sformatf("f_dn%0d", f));
        chk("slew.ch0_final", active_m[0], 32'd25);

        // Asynchronous reset mid-pulse.
        repeat (10) @(negedge clk);
        chk("arst.pwm_before", 32'(pwm[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.pwm", 32'(pwm), 32'd0);
        en = 1'b0;
        #1;
        chk("arst.cmd_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
